// File: rtl/move_input_controller_if.sv
// rtl/move_input_controller_if.sv - move request bundle from button controller to column-select datapath
interface move_input_controller_if;
  logic [3:0] column;
  logic       enable;
  logic       invalid;
  logic       busy;

  modport master (output column, output enable, output invalid, output busy);
  modport slave  (input column, input enable, input invalid, input busy);
endinterface

// File: rtl/move_input_controller.sv
// rtl/move_input_controller.sv - debounced buttons to cursor and single-cycle Connect4 move requests
module move_input_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_drop,
  input  logic [15:0]             gameboard,
  input  logic [1:0]              game_status,
  output logic [3:0]              cursor,
  move_input_controller_if.master req
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, LOCKED} state_t;

  // Button vectors are ordered {drop, right, left}.
  logic [2:0]          raw;
  logic [2:0]          sync1;
  logic [2:0]          sync2;
  logic [2:0]          level;
  logic [2:0]          level_d;
  logic [2:0]          rise;
  logic [2:0][DW-1:0]  db_cnt;
  logic [1:0]          cur;
  state_t              state;
  logic [SW-1:0]       settle_cnt;
  logic [3:0]          column_q;
  logic                enable_q;
  logic                invalid_q;
  logic                busy_q;

  assign raw = {btn_drop, btn_right, btn_left};

  // Two-stage synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows the synchronized input only after a full run of disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level  <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Registered one-cycle rise pulse per debounced button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= '0;
      rise    <= '0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

  // Cursor moves with wrap in every state except LOCKED; simultaneous left+right cancel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= 2'd0;
    end else if (state != LOCKED) begin
      if (rise[0] && !rise[1]) begin
        cur <= cur - 2'd1;
      end else if (rise[1] && !rise[0]) begin
        cur <= cur + 2'd1;
      end
    end
  end

  // Request FSM with registered column/enable/invalid/busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      column_q   <= 4'd0;
      enable_q   <= 1'b0;
      invalid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      enable_q  <= 1'b0;
      invalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (game_status != 2'b00) begin
            state  <= LOCKED;
            busy_q <= 1'b1;
          end else if (rise[2]) begin
            // Fullness is judged on the cursor before any same-cycle move.
            if (gameboard[{cur, 2'b11}]) begin
              invalid_q <= 1'b1;
            end else begin
              column_q <= {2'b00, cur};
              enable_q <= 1'b1;
              busy_q   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (game_status != 2'b00) begin
            state <= LOCKED;
          end else if (settle_cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        LOCKED: begin
          busy_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cursor      = 4'b0001 << cur;
  assign req.column  = column_q;
  assign req.enable  = enable_q;
  assign req.invalid = invalid_q;
  assign req.busy    = busy_q;

endmodule

// File: tb/tb_move_input_controller.sv
// tb/tb_move_input_controller.sv - self-checking bench for move_input_controller
module tb_move_input_controller;
  localparam int D = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_drop = 1'b0;
  logic [15:0] gameboard = 16'h0000;
  logic [1:0]  game_status = 2'b00;
  logic [3:0]  cursor;

  move_input_controller_if bus ();

  move_input_controller #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(rst_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_drop(btn_drop),
    .gameboard(gameboard),
    .game_status(game_status),
    .cursor(cursor),
    .req(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: button history windows and request timing expressed in edge numbers.
  int         e;
  logic [2:0] hq[$];
  logic [2:0] mlev;
  int         due[3];
  int         m_cur;
  bit         m_locked;
  int         t_acc;
  int         t_inv;
  int         m_col;
  bit         ev[3];
  bit         idle_now;
  bit         settle_now;
  bit         all_diff;
  int         old_cur;
  int         tb_edge = 0;

  always @(posedge clk) tb_edge++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0;
      hq.delete();
      for (int j = 0; j < D + 2; j++) hq.push_front(3'b000);
      mlev = 3'b000;
      for (int b = 0; b < 3; b++) due[b] = -1;
      m_cur = 0;
      m_locked = 0;
      t_acc = -1;
      t_inv = -1;
      m_col = 0;
    end else begin
      e++;
      hq.push_front({btn_drop, btn_right, btn_left});
      if (hq.size() > D + 2) void'(hq.pop_back());
      for (int b = 0; b < 3; b++) ev[b] = (due[b] == e);
      idle_now   = !m_locked && (t_acc < 0 || e >= t_acc + S + 2);
      settle_now = !m_locked && t_acc >= 0 && e >= t_acc + 2 && e <= t_acc + S + 1;
      old_cur = m_cur;
      if (!m_locked) begin
        if (ev[0] && !ev[1]) m_cur = (m_cur + 3) % 4;
        else if (ev[1] && !ev[0]) m_cur = (m_cur + 1) % 4;
      end
      if ((idle_now || settle_now) && game_status != 2'b00) begin
        m_locked = 1;
      end else if (idle_now && ev[2]) begin
        if (gameboard[old_cur * 4 + 3]) t_inv = e;
        else begin
          t_acc = e;
          m_col = old_cur;
        end
      end
      for (int b = 0; b < 3; b++) begin
        all_diff = 1;
        for (int j = 2; j <= D + 1; j++) if (hq[j][b] == mlev[b]) all_diff = 0;
        if (all_diff) begin
          mlev[b] = ~mlev[b];
          if (mlev[b]) due[b] = e + 2;
        end
      end
    end
  end

  int en_count = 0;
  int inv_count = 0;
  int last_en_edge = 0;
  int last_col = 0;

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("enable", int'(bus.enable), int'(t_acc == e && e > 0));
    chk("invalid", int'(bus.invalid), int'(t_inv == e && e > 0));
    chk("busy", int'(bus.busy), int'(m_locked || (t_acc >= 0 && e >= t_acc && e <= t_acc + S)));
    chk("column", int'(bus.column), m_col);
    chk("cursor", int'(cursor), 1 << m_cur);
    if (bus.enable === 1'b1) begin
      en_count++;
      last_en_edge = tb_edge;
      last_col = int'(bus.column);
    end
    if (bus.invalid === 1'b1) inv_count++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic [2:0] m);
    {btn_drop, btn_right, btn_left} = m;
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    set_btn(m);
    step(hold);
    set_btn(3'b000);
    step(12);
  endtask

  // Waits for enable (which=0) or invalid (which=1); lat counts edges, 0 on timeout.
  task automatic wait_sig(input bit which, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((which ? bus.invalid : bus.enable) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, nb, e0, i0, first_edge, c0;

  initial begin
    step(3);
    chk("reset_cursor", int'(cursor), 1);
    chk("reset_column", int'(bus.column), 0);
    chk("reset_enable", int'(bus.enable), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    step(2);

    // Clean drop on an empty board.
    btn_drop = 1'b1;
    wait_sig(0, lat);
    chk("drop_latency", lat, 8);
    chk("drop_column", int'(bus.column), 0);
    nb = 0;
    while (bus.busy === 1'b1 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 5);
    #1;
    btn_drop = 1'b0;
    step(12);

    // Cursor wrap and cancel.
    press(3'b001, 6);
    chk("left_wrap", int'(cursor), 8);
    press(3'b010, 6);
    press(3'b010, 6);
    chk("right_twice", int'(cursor), 2);
    press(3'b011, 6);
    chk("left_right_cancel", int'(cursor), 2);

    // Full column.
    press(3'b001, 6);
    press(3'b001, 6);
    chk("cursor_col3", int'(cursor), 8);
    gameboard = 16'h8000;
    e0 = en_count;
    btn_drop = 1'b1;
    wait_sig(1, lat);
    chk("invalid_latency", lat, 8);
    chk("invalid_no_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("invalid_one_cycle", int'(bus.invalid), 0);
    #1;
    btn_drop = 1'b0;
    step(12);
    chk("invalid_no_enable", en_count - e0, 0);

    // Bouncing drop.
    gameboard = 16'h0000;
    e0 = en_count;
    i0 = inv_count;
    repeat (3) begin
      btn_drop = 1'b1;
      step(2);
      btn_drop = 1'b0;
      step(2);
    end
    step(15);
    chk("bounce_no_enable", en_count - e0, 0);
    chk("bounce_no_invalid", inv_count - i0, 0);

    // Second drop pressed while the first request is busy.
    e0 = en_count;
    btn_drop = 1'b1;
    step(4);
    btn_drop = 1'b0;
    step(4);
    chk("first_busy", int'(bus.busy), 1);
    chk("first_column", int'(bus.column), 3);
    first_edge = last_en_edge;
    btn_drop = 1'b1;
    step(14);
    btn_drop = 1'b0;
    step(12);
    chk("two_enables", en_count - e0, 2);
    chk("min_spacing", int'((last_en_edge - first_edge) >= S + 2), 1);
    chk("second_column", last_col, 3);
    press(3'b010, 6);
    chk("cursor_wrap_to0", int'(cursor), 1);
    press(3'b100, 6);
    chk("third_column", last_col, 0);

    // Game over during SETTLE.
    btn_drop = 1'b1;
    wait_sig(0, lat);
    chk("gameover_enable_seen", int'(lat > 0), 1);
    #1;
    step(2);
    game_status = 2'b01;
    step(1);
    btn_drop = 1'b0;
    step(10);
    chk("locked_busy", int'(bus.busy), 1);
    c0 = int'(cursor);
    e0 = en_count;
    i0 = inv_count;
    press(3'b100, 6);
    press(3'b001, 6);
    gameboard = 16'hFFFF;
    press(3'b100, 6);
    game_status = 2'b00;
    step(5);
    chk("locked_busy_after", int'(bus.busy), 1);
    chk("locked_cursor", int'(cursor), c0);
    chk("locked_no_enable", en_count - e0, 0);
    chk("locked_no_invalid", inv_count - i0, 0);
    rst_n = 1'b0;
    step(2);
    gameboard = 16'h0000;
    rst_n = 1'b1;
    step(2);
    chk("unlock_busy", int'(bus.busy), 0);
    chk("unlock_cursor", int'(cursor), 1);

    // Reset during ISSUE.
    press(3'b010, 6);
    btn_drop = 1'b1;
    wait_sig(0, lat);
    chk("issue_column", int'(bus.column), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_kills_enable", int'(bus.enable), 0);
    step(2);
    btn_drop = 1'b0;
    rst_n = 1'b1;
    step(2);
    chk("post_reset_column", int'(bus.column), 0);
    chk("post_reset_enable", int'(bus.enable), 0);
    chk("post_reset_invalid", int'(bus.invalid), 0);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_cursor", int'(cursor), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule
